// File: rtl/ri5cy_mem_pkg.sv
// Shared types and constants for the RI5CY data-memory responder:
// grant FSM states, stall-injection LFSR constants and the response-stage
// record carried through the rvalid pipeline.
package ri5cy_mem_pkg;

  // Grant handshake states; only used when a non-zero grant wait is configured.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GRANT
  } gnt_state_e;

  // Stall-injection LFSR: 16-bit Galois form, deterministic after reset.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  // Data width carried by a response stage; the responder's DATA_WIDTH
  // defaults to this value and must match it.
  localparam int MEM_DATA_WIDTH = 32;

  // One slot of the response shift register.
  typedef struct packed {
    logic                      valid;
    logic [MEM_DATA_WIDTH-1:0] rdata;
  } resp_stage_t;

  // Next state of the Galois LFSR: shift right, fold in the polynomial
  // whenever the bit shifted out is 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return state[0] ? ((state >> 1) ^ LFSR_POLY) : (state >> 1);
  endfunction

endpackage

// File: rtl/ri5cy_mem_resp_pipe.sv
// Fixed-latency response pipeline: DEPTH stages of {valid, rdata}.
// A response entering on in_valid appears on out_valid exactly DEPTH cycles
// later. The data field of a stage only loads when a valid entry moves in,
// so out_rdata holds the last delivered value while out_valid is low.
// clr is a synchronous clear that drops every in-flight response.
module ri5cy_mem_resp_pipe
  import ri5cy_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      in_valid,
  input  logic [MEM_DATA_WIDTH-1:0] in_rdata,
  output logic                      out_valid,
  output logic [MEM_DATA_WIDTH-1:0] out_rdata
);

  resp_stage_t stage_q [DEPTH];

  // Shift responses one stage per cycle; clear everything on clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0].valid <= in_valid;
      if (in_valid) begin
        stage_q[0].rdata <= in_rdata;
      end
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i].valid <= stage_q[i-1].valid;
        if (stage_q[i-1].valid) begin
          stage_q[i].rdata <= stage_q[i-1].rdata;
        end
      end
    end
  end

  assign out_valid = stage_q[DEPTH-1].valid;
  assign out_rdata = stage_q[DEPTH-1].rdata;

endmodule

// File: rtl/ri5cy_data_mem_responder.sv
// Slave end of a RI5CY cache's data-memory request port: word-addressed RAM
// with programmable grant wait (GNT_WAIT) and read latency (RVALID_LAT).
// Optional build macro RI5CY_MEM_STALL_INJECT_EN adds an LFSR that randomly
// withholds gnt and freezes the grant FSM for protocol stress testing.
module ri5cy_data_mem_responder
  import ri5cy_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int GNT_WAIT   = 0,
  parameter int RVALID_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic [31:0]             read_count_o,
  output logic [31:0]             write_count_o
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int IDX_WIDTH = ADDR_WIDTH - 2;
  localparam int DEPTH     = 1 << IDX_WIDTH;

  logic                  stall;
  logic                  gnt;
  logic                  accept;
  logic [IDX_WIDTH-1:0]  idx;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic [1:0]            unused_addr_bits;

`ifdef RI5CY_MEM_STALL_INJECT_EN
  logic [15:0] lfsr_q;

  // Free-running stall LFSR, reseeded on reset so stall patterns repeat.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  if (GNT_WAIT == 0) begin : g_no_wait
    // Zero wait: grant follows the request directly; never grant in reset.
    assign gnt = data_req_i & ~stall & ~rst;
  end else begin : g_wait
    localparam int               CNT_WIDTH = $clog2(GNT_WAIT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(GNT_WAIT - 1);

    gnt_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Grant FSM state and wait counter registers.
    always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next state and gnt. The IDLE cycle that sees req counts as the first
    // wait cycle, so gnt lands exactly GNT_WAIT cycles after req rises.
    always_comb begin
      // NOTE: every output gets a default first so no path leaves a value
      // unassigned, which would otherwise infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt     = 1'b0;
      if (!stall) begin
        unique case (state_q)
          IDLE: begin
            if (data_req_i) begin
              cnt_d   = CNT_LOAD;
              state_d = (CNT_LOAD == '0) ? GRANT : WAIT;
            end
          end
          WAIT: begin
            if (!data_req_i) begin
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q - CNT_WIDTH'(1);
              if (cnt_d == '0) begin
                state_d = GRANT;
              end
            end
          end
          GRANT: begin
            gnt     = data_req_i & ~rst;
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign data_gnt_o       = gnt;
  assign accept           = data_req_i & gnt;
  assign idx              = data_addr_i[ADDR_WIDTH-1:2];
  assign unused_addr_bits = data_addr_i[1:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-enabled RAM write at the accept edge.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array is deliberately left out of reset so it maps onto
    // block RAM; contents survive a reset of the control logic.
    if (accept && data_we_i) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (data_be_i[b]) begin
          mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read data captured into the pipeline at the accept edge; writes answer 0.
  assign resp_rdata = data_we_i ? '0 : mem[idx];

  ri5cy_mem_resp_pipe #(
    .DEPTH(RVALID_LAT)
  ) u_resp_pipe (
    .clk      (clk),
    .clr      (rst),
    .in_valid (accept),
    .in_rdata (resp_rdata),
    .out_valid(data_rvalid_o),
    .out_rdata(data_rdata_o)
  );

  // Wrapping accept counters, split by direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_count_o  <= '0;
      write_count_o <= '0;
    end else if (accept) begin
      if (data_we_i) begin
        write_count_o <= write_count_o + 32'd1;
      end else begin
        read_count_o <= read_count_o + 32'd1;
      end
    end
  end

endmodule
